// File: rtl/fe_fifo_unpacker_if.sv
// fe_fifo_unpacker_if
//   Bundles the two handshakes of the front-end FIFO unpacker.
//   FIFO side  : I_fifo_dout (entry {data, cmd, time}), I_fifo_empty, O_fifo_rd.
//   Byte side  : O_data, O_valid, I_ready (byte moves when O_valid && I_ready).
//   Modports   : master = unpacker, slave = FIFO/consumer environment.
interface fe_fifo_unpacker_if #(
    parameter int unsigned pDATA_WIDTH           = 8,
    parameter int unsigned pTIMESTAMP_FULL_WIDTH = 16
);
    logic [pDATA_WIDTH+2+pTIMESTAMP_FULL_WIDTH-1:0] I_fifo_dout;
    logic                                           I_fifo_empty;
    logic                                           O_fifo_rd;
    logic [7:0]                                     O_data;
    logic                                           O_valid;
    logic                                           I_ready;

    modport master (
        input  I_fifo_dout,
        input  I_fifo_empty,
        input  I_ready,
        output O_fifo_rd,
        output O_data,
        output O_valid
    );

    modport slave (
        output I_fifo_dout,
        output I_fifo_empty,
        output I_ready,
        input  O_fifo_rd,
        input  O_data,
        input  O_valid
    );
endinterface

// File: rtl/fe_fifo_unpacker.sv
// fe_fifo_unpacker
//   Pops {data, cmd, time} entries from the front-end FIFO and serialises each
//   into bytes for the USB register read path:
//     data entry : header {time[SHORT-1:0], zero pad, cmd}, then data
//     TIME entry : header {6'b0, cmd}, then time[7:0], then time[15:8]
//
// Ports
//   cwusb_clk      sole clock
//   reset_i        synchronous, active-high reset
//   bus            fe_fifo_unpacker_if.master (FIFO pop side + byte stream side)
//   I_flush        abandon the current entry, clear counters, return to idle
//   O_idle         nothing held and no byte pending
//   O_entry_count  entries fully emitted since reset/flush (wraps)
//   O_byte_count   bytes accepted since reset/flush (wraps)
//
// Build option
//   FE_UNPACKER_PREFETCH_EN : adds a one-entry prefetch register so
//   back-to-back entries stream with no idle cycles. Without it every entry
//   pays two cycles (IDLE pop + WAIT capture) with O_valid low.
//
// pDATA_WIDTH is fixed at 8; pTIMESTAMP_SHORT_WIDTH must be <= 6 so the short
// timestamp fits above the 2-bit command in the header byte.
module fe_fifo_unpacker #(
    parameter int unsigned pDATA_WIDTH            = 8,
    parameter int unsigned pTIMESTAMP_FULL_WIDTH  = 16,
    parameter int unsigned pTIMESTAMP_SHORT_WIDTH = 3,
    parameter int unsigned pCOUNT_WIDTH           = 16,
    parameter logic [1:0]  pFE_FIFO_CMD_TIME      = 2'b10
) (
    input  logic                    cwusb_clk,
    input  logic                    reset_i,
    fe_fifo_unpacker_if.master      bus,
    input  logic                    I_flush,
    output logic                    O_idle,
    output logic [pCOUNT_WIDTH-1:0] O_entry_count,
    output logic [pCOUNT_WIDTH-1:0] O_byte_count
);

    localparam int unsigned EntryWidth = pDATA_WIDTH + 2 + pTIMESTAMP_FULL_WIDTH;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StHdr,
        StB1,
        StB2
    } state_e;

    state_e                  state_q, state_d;
    logic [EntryWidth-1:0]   entry_q, entry_d;
    logic [pCOUNT_WIDTH-1:0] entry_cnt_q, entry_cnt_d;
    logic [pCOUNT_WIDTH-1:0] byte_cnt_q, byte_cnt_d;

    logic                    pop;
    logic                    out_valid;
    logic [7:0]              out_data;
    logic                    done;

`ifdef FE_UNPACKER_PREFETCH_EN
    logic                    pf_valid_q, pf_valid_d;
    logic                    pf_inflight_q, pf_inflight_d;
    logic [EntryWidth-1:0]   pf_entry_q, pf_entry_d;
`endif

    // Field views of the held entry.
    logic [7:0]                       data_w;
    logic [1:0]                       cmd_w;
    logic [pTIMESTAMP_FULL_WIDTH-1:0] time_w;
    logic                             is_time;
    logic [7:0]                       hdr_byte;

    assign data_w  = entry_q[EntryWidth-1 -: 8];
    assign cmd_w   = entry_q[pTIMESTAMP_FULL_WIDTH +: 2];
    assign time_w  = entry_q[pTIMESTAMP_FULL_WIDTH-1:0];
    assign is_time = (cmd_w == pFE_FIFO_CMD_TIME);

    always_comb begin
        hdr_byte      = '0;
        hdr_byte[1:0] = cmd_w;
        // TIME entries carry the full stamp in later bytes, so no short stamp.
        if (!is_time) begin
            hdr_byte[7 -: pTIMESTAMP_SHORT_WIDTH] = time_w[pTIMESTAMP_SHORT_WIDTH-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        entry_d     = entry_q;
        entry_cnt_d = entry_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        pop         = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        done        = 1'b0;
`ifdef FE_UNPACKER_PREFETCH_EN
        pf_valid_d    = pf_valid_q;
        pf_entry_d    = pf_entry_q;
        pf_inflight_d = 1'b0;
`endif

        case (state_q)
            StIdle: begin
                if (!bus.I_fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StWait;
                end
            end
            StWait: begin
                // Entry popped last cycle is on the FIFO output now.
                entry_d = bus.I_fifo_dout;
                state_d = StHdr;
            end
            StHdr: begin
                out_valid = 1'b1;
                out_data  = hdr_byte;
                if (bus.I_ready) begin
                    state_d = StB1;
                end
            end
            StB1: begin
                out_valid = 1'b1;
                out_data  = is_time ? time_w[7:0] : data_w;
                if (bus.I_ready) begin
                    if (is_time) begin
                        state_d = StB2;
                    end else begin
                        done = 1'b1;
                    end
                end
            end
            StB2: begin
                out_valid = 1'b1;
                out_data  = time_w[15:8];
                if (bus.I_ready) begin
                    done = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (out_valid && bus.I_ready) begin
            byte_cnt_d = byte_cnt_q + 1'b1;
        end

        if (done) begin
            entry_cnt_d = entry_cnt_q + 1'b1;
            state_d     = StIdle;
        end

`ifdef FE_UNPACKER_PREFETCH_EN
        // A prefetch pop issued last cycle lands in the prefetch register.
        if (pf_inflight_q) begin
            pf_valid_d = 1'b1;
            pf_entry_d = bus.I_fifo_dout;
        end

        // Chain straight into the next header when an entry is on hand; if the
        // prefetched entry is only arriving this cycle, take it from the bus.
        if (done) begin
            if (pf_valid_q) begin
                entry_d    = pf_entry_q;
                pf_valid_d = 1'b0;
                state_d    = StHdr;
            end else if (pf_inflight_q) begin
                entry_d    = bus.I_fifo_dout;
                pf_valid_d = 1'b0;
                state_d    = StHdr;
            end
        end

        // No prefetch in the done cycle: an empty slot there means IDLE pops.
        if ((state_q == StHdr || state_q == StB1 || state_q == StB2) && !done &&
            !pf_valid_q && !pf_inflight_q && !bus.I_fifo_empty) begin
            pop           = 1'b1;
            pf_inflight_d = 1'b1;
        end
`endif

        if (I_flush) begin
            state_d     = StIdle;
            pop         = 1'b0;
            // Withhold the byte so nothing is handed over in the flush cycle.
            out_valid   = 1'b0;
            out_data    = '0;
            entry_cnt_d = '0;
            byte_cnt_d  = '0;
`ifdef FE_UNPACKER_PREFETCH_EN
            pf_valid_d    = 1'b0;
            pf_inflight_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge cwusb_clk) begin
        if (reset_i) begin
            state_q     <= StIdle;
            entry_q     <= '0;
            entry_cnt_q <= '0;
            byte_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            entry_q     <= entry_d;
            entry_cnt_q <= entry_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
        end
    end

`ifdef FE_UNPACKER_PREFETCH_EN
    always_ff @(posedge cwusb_clk) begin
        if (reset_i) begin
            pf_valid_q    <= 1'b0;
            pf_inflight_q <= 1'b0;
            pf_entry_q    <= '0;
        end else begin
            pf_valid_q    <= pf_valid_d;
            pf_inflight_q <= pf_inflight_d;
            pf_entry_q    <= pf_entry_d;
        end
    end
`endif

    assign bus.O_fifo_rd = pop && !reset_i;
    assign bus.O_valid   = out_valid;
    assign bus.O_data    = out_data;
    assign O_entry_count = entry_cnt_q;
    assign O_byte_count  = byte_cnt_q;

`ifdef FE_UNPACKER_PREFETCH_EN
    assign O_idle = (state_q == StIdle) && !out_valid && !pf_valid_q;
`else
    assign O_idle = (state_q == StIdle) && !out_valid;
`endif

endmodule

// File: tb/tb_fe_fifo_unpacker.sv
module tb_fe_fifo_unpacker;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        idle;
    logic [15:0] entry_count;
    logic [15:0] byte_count;

    fe_fifo_unpacker_if #(.pDATA_WIDTH(8), .pTIMESTAMP_FULL_WIDTH(16)) bus ();

    fe_fifo_unpacker dut (
        .cwusb_clk     (clk),
        .reset_i       (rst),
        .bus           (bus),
        .I_flush       (flush),
        .O_idle        (idle),
        .O_entry_count (entry_count),
        .O_byte_count  (byte_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // FIFO model: entry appears on dout the cycle after the pop.
    logic [25:0] mem [0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    assign bus.I_fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (bus.O_fifo_rd && (wr_ptr != rd_ptr)) begin
            bus.I_fifo_dout <= mem[rd_ptr % 64];
            rd_ptr          <= rd_ptr + 1;
        end
    end

    // Byte monitor, sampled on the falling edge.
    int          cyc       = 0;
    int          rd_seen   = 0;
    int          rd_cycle  = 0;
    int          bad_rd    = 0;
    int          stab_viol = 0;
    int          cap_n     = 0;
    logic [7:0]  cap [0:255];
    int          cap_cyc [0:255];
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data  = 8'h00;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.O_fifo_rd) begin
            rd_seen  = rd_seen + 1;
            rd_cycle = cyc;
            if (bus.I_fifo_empty) bad_rd = bad_rd + 1;
        end
        if (prev_stall && !flush && !rst) begin
            if (!bus.O_valid || bus.O_data !== prev_data) stab_viol = stab_viol + 1;
        end
        prev_stall = bus.O_valid && !bus.I_ready;
        prev_data  = bus.O_data;
        if (bus.O_valid && bus.I_ready) begin
            cap[cap_n]     = bus.O_data;
            cap_cyc[cap_n] = cyc;
            cap_n          = cap_n + 1;
        end
    end

    logic toggle = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (toggle) bus.I_ready = ~bus.I_ready;
    endtask

    task automatic push(input logic [25:0] e);
        mem[wr_ptr % 64] = e;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int k = 0;
        while (cap_n < n && k < budget) begin
            step();
            k++;
        end
        chk("byte_budget", cap_n, n);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    function automatic logic [25:0] mk(input logic [7:0] d, input logic [1:0] c,
                                       input logic [15:0] t);
        return {d, c, t};
    endfunction

    logic [7:0] mix_exp [0:8];

    initial begin
        int base;
        int r0;
        int s0;
        int idle_bad;
        int gap;

        mix_exp = '{8'hE0, 8'h3C, 8'h02, 8'hEF, 8'hBE, 8'h41, 8'h81, 8'h03, 8'h00};
        rst         = 1'b1;
        flush       = 1'b0;
        bus.I_ready = 1'b1;
        do_reset();

        // Reset state
        chk("rst_valid", bus.O_valid, 1'b0);
        chk("rst_data", bus.O_data, 8'h00);
        chk("rst_rd", bus.O_fifo_rd, 1'b0);
        chk("rst_idle", idle, 1'b1);
        chk("rst_entry_cnt", entry_count, 16'd0);
        chk("rst_byte_cnt", byte_count, 16'd0);

        // Empty FIFO for 100 cycles
        r0 = rd_seen;
        idle_bad = 0;
        repeat (100) begin
            step();
            if (idle !== 1'b1) idle_bad++;
        end
        chk("empty_no_pop", rd_seen - r0, 0);
        chk("empty_idle", idle_bad, 0);

        // Data entry, header 2 cycles after the pop cycle
        base = cap_n;
        push(mk(8'hA5, 2'b00, 16'h0005));
        wait_bytes(base + 2, 50);
        chk("data_hdr_latency", cap_cyc[base] - rd_cycle, 2);
        chk("data_hdr", cap[base], 8'hA0);
        chk("data_byte", cap[base+1], 8'hA5);
        chk("data_entry_cnt", entry_count, 16'd1);
        chk("data_byte_cnt", byte_count, 16'd2);

        // TIME entry
        do_reset();
        base = cap_n;
        push(mk(8'h00, 2'b10, 16'h1234));
        wait_bytes(base + 3, 50);
        chk("time_hdr", cap[base], 8'h02);
        chk("time_lo", cap[base+1], 8'h34);
        chk("time_hi", cap[base+2], 8'h12);
        chk("time_entry_cnt", entry_count, 16'd1);
        chk("time_byte_cnt", byte_count, 16'd3);

        // Four mixed entries, I_ready held high
        do_reset();
        base = cap_n;
        push(mk(8'h3C, 2'b00, 16'h0007));
        push(mk(8'h00, 2'b10, 16'hBEEF));
        push(mk(8'h81, 2'b01, 16'h0002));
        push(mk(8'h00, 2'b11, 16'hFFF8));
        wait_bytes(base + 9, 100);
        for (int i = 0; i < 9; i++) chk($sformatf("mix_rdy_b%0d", i), cap[base+i], mix_exp[i]);
        chk("mix_rdy_entry_cnt", entry_count, 16'd4);
        chk("mix_rdy_byte_cnt", byte_count, 16'd9);

        // Same entries, I_ready toggling
        do_reset();
        base = cap_n;
        s0 = stab_viol;
        bus.I_ready = 1'b0;
        toggle = 1'b1;
        push(mk(8'h3C, 2'b00, 16'h0007));
        push(mk(8'h00, 2'b10, 16'hBEEF));
        push(mk(8'h81, 2'b01, 16'h0002));
        push(mk(8'h00, 2'b11, 16'hFFF8));
        wait_bytes(base + 9, 200);
        toggle = 1'b0;
        bus.I_ready = 1'b1;
        for (int i = 0; i < 9; i++) chk($sformatf("mix_tog_b%0d", i), cap[base+i], mix_exp[i]);
        chk("mix_tog_stable", stab_viol - s0, 0);
        chk("mix_tog_entry_cnt", entry_count, 16'd4);
        chk("mix_tog_byte_cnt", byte_count, 16'd9);

        // Flush in B1 of a TIME entry
        do_reset();
        base = cap_n;
        push(mk(8'h00, 2'b10, 16'h5678));
        wait_bytes(base + 1, 50);
        chk("flush_pre_valid", bus.O_valid, 1'b1);
        chk("flush_pre_data", bus.O_data, 8'h78);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_valid", bus.O_valid, 1'b0);
        chk("flush_entry_cnt", entry_count, 16'd0);
        chk("flush_byte_cnt", byte_count, 16'd0);
        chk("flush_idle", idle, 1'b1);
        chk("flush_no_byte", cap_n, base + 1);
        push(mk(8'h5A, 2'b01, 16'h0003));
        wait_bytes(base + 3, 50);
        chk("post_flush_hdr", cap[base+1], 8'h61);
        chk("post_flush_data", cap[base+2], 8'h5A);
        chk("post_flush_entry_cnt", entry_count, 16'd1);
        chk("post_flush_byte_cnt", byte_count, 16'd2);

        // Eight queued data entries, I_ready high
        do_reset();
        base = cap_n;
        for (int i = 0; i < 8; i++) push(mk(8'h10 + 8'(i), 2'b00, 16'(i)));
        wait_bytes(base + 16, 200);
`ifdef FE_UNPACKER_PREFETCH_EN
        gap = 1;
`else
        gap = 3;
`endif
        for (int i = 0; i < 8; i++) begin
            logic [7:0] eh;
            eh = 8'(i << 5);
            chk($sformatf("burst_hdr%0d", i), cap[base+2*i], eh);
            chk($sformatf("burst_data%0d", i), cap[base+2*i+1], 8'h10 + 8'(i));
        end
        for (int k = 1; k < 16; k++) begin
            chk($sformatf("burst_gap%0d", k), cap_cyc[base+k] - cap_cyc[base+k-1],
                (k % 2 == 1) ? 1 : gap);
        end
        chk("burst_entry_cnt", entry_count, 16'd8);
        chk("burst_byte_cnt", byte_count, 16'd16);
        chk("no_pop_when_empty", bad_rd, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
